fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage that drives the instruction memory: it owns the program counter and presents a 5-bit word address every cycle.
- Tracks the one-cycle synchronous read latency of the memory, pairing each returned instruction with its PC and a valid flag for decode.
- Supports a pipeline stall (hold) and a control-flow redirect (branch/jump) that squashes the wrong-path fetch.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset.
- ADDR_W, 5, instruction-memory word-address width; imem_addr = pc[ADDR_W+1:2].
- NOP_INSTR, 32'h0000_0000, value driven on if_instr when if_valid = 0.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  decode cannot accept; hold the current output.
- redirect  input  1  take a new PC (branch/jump resolved).
- redirect_pc  input  32  target byte address; bits [1:0] ignored (forced 0).
- imem_addr  output  ADDR_W  word address to instruction memory (combinational from state).
- imem_instr  input  32  instruction memory registered read data (valid 1 cycle after its address).
- if_instr  output  32  fetched instruction (NOP_INSTR when not valid).
- if_pc  output  32  byte PC of if_instr.
- if_valid  output  1  if_instr/if_pc hold a real, correct-path instruction.

Behaviour:
- State: fetch_pc (32b, address being presented), out_pc (32b), out_valid (1b). if_pc = out_pc; if_valid = out_valid; if_instr = out_valid ? imem_instr : NOP_INSTR.
- imem_addr = (stall && !redirect && !rst) ? out_pc[ADDR_W+1:2] : fetch_pc[ADDR_W+1:2]. During a stall the memory re-reads the word already on the output, so if_instr stays stable.
- Reset (rst = 1 at posedge): fetch_pc <= RESET_PC & ~3, out_pc <= 0, out_valid <= 0. stall and redirect are ignored while rst = 1.
- Priority per posedge: rst > redirect > stall > normal.
- Normal (no stall, no redirect): out_pc <= fetch_pc; out_valid <= 1; fetch_pc <= fetch_pc + 4.
- Stall only: fetch_pc, out_pc and out_valid hold. A stall with out_valid = 0 keeps the bubble.
- Redirect (with or without stall): fetch_pc <= {redirect_pc[31:2], 2'b00}; out_valid <= 0; out_pc holds. The cycle after, imem_addr = target; one cycle later if_valid = 1 with if_pc = target. The redirect penalty is exactly 1 bubble.
- Latency: first valid output appears on the first posedge with rst = 0, with if_pc = RESET_PC. After that the unit sustains 1 instruction per cycle while not stalled.
- Wrap: fetch_pc is a full 32-bit adder and wraps 0xFFFF_FFFC -> 0. The memory index wraps modulo 2^ADDR_W words (PC 0x80 reads word 0), and if_pc reports the full PC.
- Back-to-back redirects: each redirect supersedes the previous one; out_valid stays 0 until a non-redirect cycle.
- Reset mid-stall or mid-redirect: state is reset and the pending target is discarded.

Test Plan:
- Memory words 0..4 = 20010003, 20020003, 00221818, 8C41000A, 10220014 (hex); release rst -> on successive posedges (if_pc, if_instr) = (0,20010003), (4,20020003), (8,00221818), (C,8C41000A), (10,10220014); if_valid stays 1.
- Hold rst high for 3 cycles -> if_valid = 0 and if_instr = 0 throughout. First cycle after release -> if_pc = 0, if_valid = 1.
- Assert stall for 2 cycles while if_pc = 8 -> if_pc = 8 and if_instr = 00221818 for those cycles. Then proceed to pc C with no skipped or duplicated word.
- Redirect to 0x4 while if_pc = 0xC -> next cycle if_valid = 0. Following cycle if_pc = 4, if_instr = 20020003, then 8, 0xC.
- Redirect with stall asserted the same cycle, target 0x13 -> redirect wins, with the target aligned to 0x10. One bubble, then if_pc = 0x10, if_instr = 10220014.
- Run sequential fetch from PC 0x7C -> imem_addr goes 31 then 0, and if_pc = 0x7C then 0x80 with if_instr = word 31 then word 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and a
// synchronous-read instruction memory (slave).
interface fetch_unit_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_instr;

    modport master (
        output imem_addr,
        input  imem_instr
    );

    modport slave (
        input  imem_addr,
        output imem_instr
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory and pairs
// each returned word (one-cycle read latency) with its PC and a valid flag.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ADDR_W    = 5,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    fetch_unit_if.master        imem,
    output logic [31:0]         if_instr,
    output logic [31:0]         if_pc,
    output logic                if_valid
);

    logic [31:0] fetch_pc_reg;
    logic [31:0] out_pc_reg;
    logic        out_valid_reg;
    logic [31:0] redirect_target;
    logic        hold_output;

    assign redirect_target = redirect_pc & ~32'd3;

    // While stalled the memory re-reads the word already on the output,
    // so the registered read data (and hence if_instr) stays stable.
    assign hold_output    = stall && !redirect && !rst;
    assign imem.imem_addr = hold_output ? out_pc_reg[ADDR_W+1:2]
                                        : fetch_pc_reg[ADDR_W+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg  <= RESET_PC & ~32'd3;
            out_pc_reg    <= 32'd0;
            out_valid_reg <= 1'b0;
        end else if (redirect) begin
            // The word being read this cycle is wrong-path: squash it.
            fetch_pc_reg  <= redirect_target;
            out_valid_reg <= 1'b0;
        end else if (!stall) begin
            out_pc_reg    <= fetch_pc_reg;
            out_valid_reg <= 1'b1;
            fetch_pc_reg  <= fetch_pc_reg + 32'd4;
        end
    end

    assign if_pc    = out_pc_reg;
    assign if_valid = out_valid_reg;
    assign if_instr = out_valid_reg ? imem.imem_instr : NOP_INSTR;

endmodule
